// File: rtl/draw_projectile_if.sv
// VGA stream bundle shared by the draw stages: timing counters, syncs, blanking and pixel colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_projectile.sv
// Launches a ball on fire, moves it once per frame under gravity, overlays it on the
// video stream and flags a hit on the cat rectangle or a miss at the field edges.
module draw_projectile #(
  parameter int          START_X    = 900,
  parameter int          START_Y    = 400,
  parameter int          BALL_SIZE  = 12,
  parameter logic [11:0] BALL_COLOR = 12'hFFF,
  parameter int          GRAVITY    = 1,
  parameter int          TARGET_X   = 0,
  parameter int          TARGET_Y   = 430,
  parameter int          TARGET_W   = 157,
  parameter int          TARGET_H   = 99,
  parameter int          GROUND_Y   = 529
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fire,
  input  logic [5:0] vx,
  input  logic [5:0] vy,
  output logic       busy,
  output logic       hit_cat,
  output logic       miss,
  vga_if.vga_in      vga_in,
  vga_if.vga_out     vga_out
);

  localparam logic signed [11:0] START_X_S = 12'(START_X);
  localparam logic signed [11:0] START_Y_S = 12'(START_Y);
  localparam logic signed [11:0] SIZE_S    = 12'(BALL_SIZE);
  localparam logic signed [11:0] TGT_L     = 12'(TARGET_X);
  localparam logic signed [11:0] TGT_R     = 12'(TARGET_X + TARGET_W);
  localparam logic signed [11:0] TGT_T     = 12'(TARGET_Y);
  localparam logic signed [11:0] TGT_B     = 12'(TARGET_Y + TARGET_H);
  localparam logic signed [11:0] GROUND_S  = 12'(GROUND_Y);
  localparam logic signed [7:0]  GRAV_S    = 8'(GRAVITY);

  typedef enum logic [1:0] {IDLE, FLY, CHECK} state_t;

  state_t             state_q, state_d;
  logic signed [11:0] px_q, px_d;
  logic signed [11:0] py_q, py_d;
  logic signed [7:0]  vel_y_q, vel_y_d;
  logic [5:0]         vx_q, vx_d;
  logic               busy_q, busy_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic [11:0] rgb_q, rgb_d;

  logic               tick;
  logic               overlap;
  logic               out_of_field;
  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic               ball_px;

  // The delayed vsync doubles as the edge detector for the once-per-frame update.
  assign tick = vga_in.vsync & ~vsync_q;

  assign overlap = (px_q < TGT_R) && ((px_q + SIZE_S) > TGT_L) &&
                   (py_q < TGT_B) && ((py_q + SIZE_S) > TGT_T);
  assign out_of_field = px_q[11] || (py_q >= GROUND_S);

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    vel_y_d = vel_y_q;
    vx_d    = vx_q;
    busy_d  = busy_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fire) begin
          px_d    = START_X_S;
          py_d    = START_Y_S;
          vel_y_d = -$signed({2'b00, vy});
          vx_d    = vx;
          busy_d  = 1'b1;
          state_d = FLY;
        end
      end
      FLY: begin
        if (tick) begin
          px_d    = px_q - $signed({6'b000000, vx_q});
          py_d    = py_q + $signed({{4{vel_y_q[7]}}, vel_y_q});
          vel_y_d = vel_y_q + GRAV_S;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // A hit wins over a miss when the ball lands on the cat in the same frame.
        if (overlap) begin
          hit_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (out_of_field) begin
          miss_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = FLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hcount_d = vga_in.hcount;
    vcount_d = vga_in.vcount;
    hsync_d  = vga_in.hsync;
    vsync_d  = vga_in.vsync;
    hblnk_d  = vga_in.hblnk;
    vblnk_d  = vga_in.vblnk;
    rgb_d    = vga_in.rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      px_q     <= START_X_S;
      py_q     <= START_Y_S;
      vel_y_q  <= '0;
      vx_q     <= '0;
      busy_q   <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      vel_y_q  <= vel_y_d;
      vx_q     <= vx_d;
      busy_q   <= busy_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      rgb_q    <= rgb_d;
    end
  end

  // Screen counters are unsigned, so ball pixels at negative coordinates can never match.
  assign hpos = $signed({1'b0, hcount_q});
  assign vpos = $signed({1'b0, vcount_q});
  assign ball_px = busy_q && !hblnk_q && !vblnk_q &&
                   (hpos >= px_q) && (hpos < (px_q + SIZE_S)) &&
                   (vpos >= py_q) && (vpos < (py_q + SIZE_S));

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = ball_px ? BALL_COLOR : rgb_q;

  assign busy    = busy_q;
  assign hit_cat = hit_q;
  assign miss    = miss_q;

endmodule

// File: tb/tb_draw_projectile.sv
// Directed bench for draw_projectile: straight hit, left and ground misses, fire while busy,
// overlay pixels and reset mid-flight, across three differently parameterised instances.
module tb_draw_projectile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] fire;
  logic [5:0] vx;
  logic [5:0] vy;
  logic [2:0] busyV;
  logic [2:0] hitV;
  logic [2:0] missV;

  int errors = 0;
  int checks = 0;
  int hitCycles[3];
  int hitFirst[3];
  int missCycles[3];
  int missFirst[3];

  // Overlay vectors against a ball at (900,400): columns 900..911, rows 400..411.
  int          ovH[7]     = '{905, 912, 899, 905, 911, 900, 905};
  int          ovV[7]     = '{405, 400, 405, 405, 411, 412, 405};
  logic        ovHs[7]    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        ovHb[7]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        ovVb[7]    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [11:0] ovRgb[7]   = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'h0F0, 12'h00F, 12'h321};
  logic [11:0] ovExpect[7] = '{12'hFFF, 12'h456, 12'h789, 12'hABC, 12'hFFF, 12'h00F, 12'h321};

  vga_if vin();
  vga_if outA();
  vga_if outB();
  vga_if outC();

  always #5 clk = ~clk;

  draw_projectile #(.START_Y(440), .GRAVITY(0)) dutA (
    .clk(clk), .rst_n(rst_n), .fire(fire[0]), .vx(vx), .vy(vy),
    .busy(busyV[0]), .hit_cat(hitV[0]), .miss(missV[0]),
    .vga_in(vin), .vga_out(outA)
  );

  draw_projectile #(.START_Y(300), .GRAVITY(0)) dutB (
    .clk(clk), .rst_n(rst_n), .fire(fire[1]), .vx(vx), .vy(vy),
    .busy(busyV[1]), .hit_cat(hitV[1]), .miss(missV[1]),
    .vga_in(vin), .vga_out(outB)
  );

  draw_projectile dutC (
    .clk(clk), .rst_n(rst_n), .fire(fire[2]), .vx(vx), .vy(vy),
    .busy(busyV[2]), .hit_cat(hitV[2]), .miss(missV[2]),
    .vga_in(vin), .vga_out(outC)
  );

  // Counts one comparison and reports it when observed and expected disagree.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // One frame: raise vsync for a cycle, then watch five negedges for pulses on every
  // instance, optionally driving fire on the instances in fireMask at negedge fireIdx.
  task automatic applyStimulus(input logic [2:0] fireMask, input int fireIdx);
    for (int d = 0; d < 3; d++) begin
      hitCycles[d]  = 0;
      hitFirst[d]   = 0;
      missCycles[d] = 0;
      missFirst[d]  = 0;
    end
    @(negedge clk);
    vin.vsync = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) vin.vsync = 1'b0;
      for (int d = 0; d < 3; d++) begin
        if (hitV[d]) begin
          hitCycles[d]++;
          if (hitFirst[d] == 0) hitFirst[d] = i;
        end
        if (missV[d]) begin
          missCycles[d]++;
          if (missFirst[d] == 0) missFirst[d] = i;
        end
      end
      fire = (i == fireIdx) ? fireMask : 3'b000;
    end
  endtask

  // Runs n frames and returns the total pulse cycles seen on instance d.
  task automatic runFrames(input int n, input int d, input logic [2:0] fireMask,
                           input int fireFrame, output int pulses);
    pulses = 0;
    for (int f = 1; f <= n; f++) begin
      applyStimulus((f == fireFrame) ? fireMask : 3'b000, 1);
      pulses += hitCycles[d] + missCycles[d];
    end
  endtask

  task automatic launch(input logic [2:0] mask, input logic [5:0] vxv, input logic [5:0] vyv);
    @(negedge clk);
    vx   = vxv;
    vy   = vyv;
    fire = mask;
    @(negedge clk);
    fire = 3'b000;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    rst_n      = 1'b0;
    fire       = 3'b000;
    vx         = '0;
    vy         = '0;
    vin.hcount = 11'd100;
    vin.vcount = 11'd200;
    vin.hsync  = 1'b1;
    vin.vsync  = 1'b0;
    vin.hblnk  = 1'b1;
    vin.vblnk  = 1'b1;
    vin.rgb    = 12'h555;

    repeat (3) @(negedge clk);
    checkOutput("reset busy", {29'd0, busyV}, 32'd0);
    checkOutput("reset hit", {29'd0, hitV}, 32'd0);
    checkOutput("reset miss", {29'd0, missV}, 32'd0);
    checkOutput("reset hcount", {21'd0, outC.hcount}, 32'd0);
    checkOutput("reset hsync", {31'd0, outC.hsync}, 32'd0);
    checkOutput("reset rgb", {20'd0, outC.rgb}, 32'd0);
    rst_n      = 1'b1;
    vin.hcount = '0;
    vin.vcount = '0;
    vin.hsync  = 1'b0;
    vin.hblnk  = 1'b0;
    vin.vblnk  = 1'b0;
    vin.rgb    = '0;
    @(negedge clk);
    checkOutput("idle busy", {31'd0, busyV[0]}, 32'd0);

    // Straight-line hit with a second fire ignored mid-flight, then a relaunch on return.
    launch(3'b001, 6'd30, 6'd0);
    checkOutput("hit launch busy", {31'd0, busyV[0]}, 32'd1);
    runFrames(24, 0, 3'b001, 3, pulses);
    checkOutput("hit frames 1-24 pulses", pulses, 0);
    checkOutput("hit frame 24 busy", {31'd0, busyV[0]}, 32'd1);
    applyStimulus(3'b001, 2);
    checkOutput("hit pulse width", hitCycles[0], 1);
    checkOutput("hit pulse timing", hitFirst[0], 2);
    checkOutput("hit no miss", missCycles[0], 0);
    checkOutput("relaunch busy", {31'd0, busyV[0]}, 32'd1);
    runFrames(24, 0, 3'b000, 0, pulses);
    checkOutput("relaunch frames 1-24 pulses", pulses, 0);
    applyStimulus(3'b000, 0);
    checkOutput("relaunch hit width", hitCycles[0], 1);
    checkOutput("relaunch hit timing", hitFirst[0], 2);
    checkOutput("relaunch no miss", missCycles[0], 0);
    checkOutput("hit busy falls", {31'd0, busyV[0]}, 32'd0);

    // Left-edge miss: px reaches 0 at frame 30 and -30 at frame 31.
    launch(3'b010, 6'd30, 6'd0);
    runFrames(30, 1, 3'b000, 0, pulses);
    checkOutput("left frames 1-30 pulses", pulses, 0);
    applyStimulus(3'b000, 0);
    checkOutput("left miss width", missCycles[1], 1);
    checkOutput("left miss timing", missFirst[1], 2);
    checkOutput("left no hit", hitCycles[1], 0);
    checkOutput("left busy falls", {31'd0, busyV[1]}, 32'd0);

    // Ground miss: py = 400 + n(n-1)/2, so 520 after tick 16 and 536 after tick 17.
    launch(3'b100, 6'd0, 6'd0);
    runFrames(16, 2, 3'b000, 0, pulses);
    checkOutput("ground frames 1-16 pulses", pulses, 0);
    applyStimulus(3'b000, 0);
    checkOutput("ground miss width", missCycles[2], 1);
    checkOutput("ground miss timing", missFirst[2], 2);
    checkOutput("ground no hit", hitCycles[2], 0);
    checkOutput("ground busy falls", {31'd0, busyV[2]}, 32'd0);

    // Overlay with the ball parked at the launch point (no tick during this stretch).
    launch(3'b100, 6'd0, 6'd0);
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checkOutput($sformatf("overlay rgb %0d", i - 1), {20'd0, outC.rgb}, {20'd0, ovExpect[i - 1]});
        checkOutput($sformatf("overlay hcount %0d", i - 1), {21'd0, outC.hcount}, 32'(ovH[i - 1]));
        checkOutput($sformatf("overlay vcount %0d", i - 1), {21'd0, outC.vcount}, 32'(ovV[i - 1]));
        checkOutput($sformatf("overlay hsync %0d", i - 1), {31'd0, outC.hsync}, {31'd0, ovHs[i - 1]});
        checkOutput($sformatf("overlay hblnk %0d", i - 1), {31'd0, outC.hblnk}, {31'd0, ovHb[i - 1]});
        checkOutput($sformatf("overlay vblnk %0d", i - 1), {31'd0, outC.vblnk}, {31'd0, ovVb[i - 1]});
      end
      if (i < 7) begin
        vin.hcount = 11'(ovH[i]);
        vin.vcount = 11'(ovV[i]);
        vin.hsync  = ovHs[i];
        vin.hblnk  = ovHb[i];
        vin.vblnk  = ovVb[i];
        vin.rgb    = ovRgb[i];
      end
    end

    // Reset mid-flight: after 5 ticks py=410, so (905,415) lies on the ball.
    vin.hcount = 11'd905;
    vin.vcount = 11'd415;
    vin.hsync  = 1'b1;
    vin.hblnk  = 1'b0;
    vin.vblnk  = 1'b0;
    vin.rgb    = 12'hABC;
    runFrames(5, 2, 3'b000, 0, pulses);
    checkOutput("pre-reset pulses", pulses, 0);
    checkOutput("pre-reset ball drawn", {20'd0, outC.rgb}, 32'hFFF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", {29'd0, busyV}, 32'd0);
    checkOutput("async reset pulses", {26'd0, hitV, missV}, 32'd0);
    checkOutput("async reset hcount", {21'd0, outC.hcount}, 32'd0);
    checkOutput("async reset vcount", {21'd0, outC.vcount}, 32'd0);
    checkOutput("async reset hsync", {31'd0, outC.hsync}, 32'd0);
    checkOutput("async reset rgb", {20'd0, outC.rgb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset no ball", {20'd0, outC.rgb}, 32'hABC);
    checkOutput("post-reset busy", {31'd0, busyV[2]}, 32'd0);
    runFrames(20, 2, 3'b000, 0, pulses);
    checkOutput("post-reset pulses", pulses, 0);
    checkOutput("post-reset still no ball", {20'd0, outC.rgb}, 32'hABC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
